uart_tx_buffered: RTL and testbench

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_tx_buffered.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffered
// Purpose  : Buffered UART transmitter. Bytes written on wr_data are queued in
//            a DEPTH-entry FIFO and sent as 8-bit frames (start, 8 data bits
//            LSB first, optional parity, one stop bit). Every line bit lasts
//            CLOCK/BAUDRATE clk cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLOCK      : clk frequency in Hz
//   BAUDRATE   : line rate in bit/s
//   DEPTH      : FIFO entries (power of 2, >= 2)
//   PARITY_EN  : 1 inserts a parity bit after the data bits
//   PARITY_ODD : 0 even parity, 1 odd parity
// Ports
//   clk      in   1              rising-edge clock
//   n_reset  in   1              synchronous active-low reset
//   wr_en    in   1              push wr_data when the FIFO is not full
//   wr_data  in   8              byte to transmit
//   full     out  1              FIFO holds DEPTH entries
//   empty    out  1              FIFO holds no entries
//   count    out  log2(DEPTH)+1  FIFO occupancy
//   overflow out  1              sticky: a write was dropped on a full FIFO
//   busy     out  1              a frame is on the line
//   tx_pin   out  1              registered serial line, idles high
// ============================================================================
module uart_tx_buffered #(
    parameter int CLOCK      = 50000000,
    parameter int BAUDRATE   = 115200,
    parameter int DEPTH      = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     busy,
    output logic                     tx_pin
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_aw        = $clog2(DEPTH);
    localparam int c_bit_ticks = CLOCK / BAUDRATE;
    // +1 keeps the width at least one bit even when a bit lasts one cycle
    localparam int c_bw        = $clog2(c_bit_ticks + 1);

    localparam logic [c_aw:0]   c_depth     = (c_aw + 1)'(DEPTH);
    localparam logic [c_bw-1:0] c_last_tick = c_bw'(c_bit_ticks - 1);
    localparam logic            c_par_en    = (PARITY_EN != 0);
    localparam logic            c_par_odd   = (PARITY_ODD != 0);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    // ------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [7:0]      mem_q [DEPTH];
    logic [c_aw-1:0] wr_ptr_q;
    logic [c_aw-1:0] rd_ptr_q;
    logic [c_aw:0]   count_q;
    logic            overflow_q;

    // ------------------------------------------------------------------------
    // Transmitter state
    // ------------------------------------------------------------------------
    logic [2:0]      state_q,  state_d;
    logic [c_bw-1:0] baud_q,   baud_d;
    logic [2:0]      bit_q,    bit_d;
    logic [7:0]      shreg_q,  shreg_d;
    logic            par_q,    par_d;
    logic            tx_q,     tx_d;

    logic            w_push;
    logic            w_pop;
    logic            w_tick_last;

    // Flags come straight from the registered occupancy, so they always show
    // the state left by the previous edge.
    assign full     = (count_q == c_depth);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != c_st_idle);
    assign tx_pin   = tx_q;

    assign w_tick_last = (baud_q == c_last_tick);
    assign w_push      = wr_en & ~full;

    // A pop only ever looks at the registered empty flag: a byte written on
    // this cycle cannot be popped until the following one.
    assign w_pop = ~empty & ((state_q == c_st_idle) |
                             ((state_q == c_st_stop) & w_tick_last));

    // ------------------------------------------------------------------------
    // FIFO write port (no reset needed: pointers define validity)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (n_reset && w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers, occupancy and sticky overflow
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_aw'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_aw'(1);
            end
            // Push is blocked when full and pop when empty, so the count
            // cannot leave 0..DEPTH.
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (c_aw + 1)'(1);
                2'b01:   count_q <= count_q - (c_aw + 1)'(1);
                default: count_q <= count_q;
            endcase
            // The full flag is the pre-edge one, so a write dropped on a
            // full FIFO stays dropped even if a pop frees a slot this edge.
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (!empty) begin
                    state_d = c_st_start;
                end
            end
            c_st_start: begin
                if (w_tick_last) begin
                    state_d = c_st_data;
                end
            end
            c_st_data: begin
                if (w_tick_last && (bit_q == 3'd7)) begin
                    state_d = c_par_en ? c_st_parity : c_st_stop;
                end
            end
            c_st_parity: begin
                if (w_tick_last) begin
                    state_d = c_st_stop;
                end
            end
            c_st_stop: begin
                // Going straight to START keeps back-to-back frames gapless.
                if (w_tick_last) begin
                    state_d = empty ? c_st_idle : c_st_start;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath next values: baud counter, bit index, shift register, parity
    // ------------------------------------------------------------------------
    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        if (w_pop) begin
            // Each frame restarts the baud counter, so frames are not tied to
            // any free-running tick. The byte is captured here, so later
            // changes of wr_data or the FIFO cannot disturb this frame.
            baud_d  = '0;
            bit_d   = 3'd0;
            shreg_d = mem_q[rd_ptr_q];
            par_d   = (^mem_q[rd_ptr_q]) ^ c_par_odd;
        end else if (state_q != c_st_idle) begin
            if (w_tick_last) begin
                baud_d = '0;
                if (state_q == c_st_data) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                end
            end else begin
                baud_d = baud_q + c_bw'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: output logic. The line value is derived from the next state so the
    // registered tx_pin changes on the same edge as the state.
    // ------------------------------------------------------------------------
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            c_st_start:  tx_d = 1'b0;
            c_st_data:   tx_d = shreg_d[0];
            c_st_parity: tx_d = par_d;
            c_st_stop:   tx_d = 1'b1;
            default:     tx_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and line registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffered
// Purpose  : Self-checking bench for uart_tx_buffered. Two instances run at
//            10 clk cycles per bit: dut0 without parity, dut1 with even
//            parity. Accepted bytes are queued as expectations; a line
//            monitor per instance decodes frames cycle by cycle and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    localparam int TB_CLOCK     = 1000000;
    localparam int TB_BAUD      = 100000;
    localparam int TB_TICKS     = 10;
    localparam int TB_DEPTH     = 8;
    localparam int TB_PAR_ODD   = 0;

    logic       clk;
    logic       n_reset;
    logic       wr_en0, wr_en1;
    logic [7:0] wr_data0, wr_data1;
    logic       full0, full1, empty0, empty1;
    logic [3:0] count0, count1;
    logic       overflow0, overflow1, busy0, busy1, tx0, tx1;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         frames0  = 0;
    int         frames1  = 0;
    bit         abort0   = 1'b0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         start_t0[$];
    int         start_t1[$];
    int         saved;

    uart_tx_buffered #(
        .CLOCK(TB_CLOCK), .BAUDRATE(TB_BAUD), .DEPTH(TB_DEPTH),
        .PARITY_EN(0), .PARITY_ODD(0)
    ) dut0 (
        .clk(clk), .n_reset(n_reset), .wr_en(wr_en0), .wr_data(wr_data0),
        .full(full0), .empty(empty0), .count(count0), .overflow(overflow0),
        .busy(busy0), .tx_pin(tx0)
    );

    uart_tx_buffered #(
        .CLOCK(TB_CLOCK), .BAUDRATE(TB_BAUD), .DEPTH(TB_DEPTH),
        .PARITY_EN(1), .PARITY_ODD(TB_PAR_ODD)
    ) dut1 (
        .clk(clk), .n_reset(n_reset), .wr_en(wr_en1), .wr_data(wr_data1),
        .full(full1), .empty(empty1), .count(count1), .overflow(overflow1),
        .busy(busy1), .tx_pin(tx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic line_of(input int inst);
        return (inst == 0) ? tx0 : tx1;
    endfunction

    // Decode frames on one line; every cycle of every bit is compared.
    task automatic monitor(input int inst);
        int         nb;
        logic [7:0] d;
        logic       eb;
        bit         ok;
        nb = (inst == 0) ? 10 : 11;
        forever begin
            @(negedge clk);
            if (line_of(inst) == 1'b0) begin
                d = 8'h00;
                if (inst == 0) begin
                    start_t0.push_back(cyc);
                    frames0++;
                    if (exp_q0.size() > 0) d = exp_q0.pop_front();
                    else chk("spurious_frame0", 32'd1, 32'd0);
                end else begin
                    start_t1.push_back(cyc);
                    frames1++;
                    if (exp_q1.size() > 0) d = exp_q1.pop_front();
                    else chk("spurious_frame1", 32'd1, 32'd0);
                end
                ok = 1'b1;
                for (int b = 0; b < nb && ok; b++) begin
                    if (b == 0)           eb = 1'b0;
                    else if (b <= 8)      eb = d[b-1];
                    else if (b == nb - 1) eb = 1'b1;
                    else                  eb = (^d) ^ TB_PAR_ODD[0];
                    for (int k = 0; k < TB_TICKS && ok; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (inst == 0 && abort0) begin
                            abort0 = 1'b0;
                            ok = 1'b0;
                        end else begin
                            chk((inst == 0) ? "line0" : "line1",
                                32'(line_of(inst)), 32'(eb));
                        end
                    end
                end
            end
        end
    endtask

    task automatic write0(input logic [7:0] d, input bit acc);
        wr_en0   = 1'b1;
        wr_data0 = d;
        if (acc) exp_q0.push_back(d);
    endtask

    task automatic write1(input logic [7:0] d);
        wr_en1   = 1'b1;
        wr_data1 = d;
        exp_q1.push_back(d);
    endtask

    // One reset cycle; a write presented meanwhile must be ignored.
    task automatic do_reset();
        @(negedge clk);
        n_reset  = 1'b0;
        wr_en0   = 1'b1;
        wr_data0 = 8'h77;
        @(negedge clk);
        n_reset  = 1'b1;
        wr_en0   = 1'b0;
        chk("rst_count", 32'(count0), 32'd0);
        chk("rst_overflow", 32'(overflow0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_reset  = 1'b0;
        wr_en0   = 1'b0;
        wr_data0 = 8'h00;
        wr_en1   = 1'b0;
        wr_data1 = 8'h00;
        fork
            monitor(0);
            monitor(1);
        join_none
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx0), 32'd1);
        chk("reset_busy", 32'(busy0), 32'd0);
        chk("reset_empty", 32'(empty0), 32'd1);
        chk("reset_full", 32'(full0), 32'd0);
        chk("reset_count", 32'(count0), 32'd0);
        chk("reset_overflow", 32'(overflow0), 32'd0);
        n_reset = 1'b1;

        // Single byte, latency and frame length
        @(negedge clk);
        write0(8'hA5, 1'b1);
        @(negedge clk);
        wr_en0 = 1'b0;
        chk("lat_count1", 32'(count0), 32'd1);
        chk("lat_tx_high", 32'(tx0), 32'd1);
        chk("lat_busy0", 32'(busy0), 32'd0);
        @(negedge clk);
        chk("lat_tx_low", 32'(tx0), 32'd0);
        chk("lat_busy1", 32'(busy0), 32'd1);
        chk("lat_count0", 32'(count0), 32'd0);
        repeat (99) @(negedge clk);
        chk("stop_busy", 32'(busy0), 32'd1);
        @(negedge clk);
        chk("end_busy", 32'(busy0), 32'd0);
        chk("end_tx", 32'(tx0), 32'd1);

        // Parity frames on dut1: 0xA5 -> 0, 0x07 -> 1, 110 cycles each
        start_t1.delete();
        @(negedge clk);
        write1(8'hA5);
        @(negedge clk);
        write1(8'h07);
        @(negedge clk);
        wr_en1 = 1'b0;
        repeat (240) @(negedge clk);
        chk("par_frames", 32'(start_t1.size()), 32'd2);
        if (start_t1.size() == 2)
            chk("par_spacing", 32'(start_t1[1] - start_t1[0]), 32'd110);
        chk("par_busy", 32'(busy1), 32'd0);

        // Back-to-back frames with no gap
        start_t0.delete();
        @(negedge clk);
        write0(8'h55, 1'b1);
        @(negedge clk);
        write0(8'hAA, 1'b1);
        @(negedge clk);
        wr_en0 = 1'b0;
        repeat (210) @(negedge clk);
        chk("b2b_frames", 32'(start_t0.size()), 32'd2);
        if (start_t0.size() == 2)
            chk("b2b_spacing", 32'(start_t0[1] - start_t0[0]), 32'd100);
        chk("b2b_empty", 32'(empty0), 32'd1);

        // Full / overflow with the line busy
        do_reset();
        @(negedge clk);
        chk("ign_count", 32'(count0), 32'd0);
        write0(8'hF0, 1'b1);
        @(negedge clk);
        wr_en0 = 1'b0;
        @(negedge clk);
        chk("full_popped", 32'(count0), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            if (i == 9) begin
                chk("full_flag", 32'(full0), 32'd1);
                chk("full_count", 32'(count0), 32'd8);
                chk("full_no_ovf", 32'(overflow0), 32'd0);
            end
            write0(8'(i), i <= 8);
            @(negedge clk);
        end
        wr_en0 = 1'b0;
        chk("ovf_flag", 32'(overflow0), 32'd1);
        chk("ovf_count", 32'(count0), 32'd8);
        repeat (920) @(negedge clk);
        chk("ovf_drained", 32'(exp_q0.size()), 32'd0);
        chk("ovf_busy", 32'(busy0), 32'd0);
        chk("ovf_sticky", 32'(overflow0), 32'd1);

        // Reset in the middle of a frame with 3 bytes queued
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            write0(8'h31 + 8'(i), 1'b1);
            @(negedge clk);
        end
        wr_en0 = 1'b0;
        repeat (26) @(negedge clk);
        chk("mid_count", 32'(count0), 32'd3);
        abort0 = 1'b1;
        exp_q0.delete();
        saved = frames0;
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        chk("mid_tx", 32'(tx0), 32'd1);
        chk("mid_count0", 32'(count0), 32'd0);
        chk("mid_busy", 32'(busy0), 32'd0);
        chk("mid_empty", 32'(empty0), 32'd1);
        repeat (300) @(negedge clk);
        chk("mid_no_frames", 32'(frames0), 32'(saved));
        chk("mid_tx_idle", 32'(tx0), 32'd1);

        // Write on a full FIFO during the STOP-exit pop
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            write0(8'h10 + 8'(i), 1'b1);
            @(negedge clk);
        end
        wr_en0 = 1'b0;
        chk("sim_count8", 32'(count0), 32'd8);
        repeat (92) @(negedge clk);
        chk("sim_pre_full", 32'(full0), 32'd1);
        chk("sim_pre_ovf", 32'(overflow0), 32'd0);
        write0(8'h99, 1'b0);
        @(negedge clk);
        wr_en0 = 1'b0;
        chk("sim_ovf", 32'(overflow0), 32'd1);
        chk("sim_count7", 32'(count0), 32'd7);
        chk("sim_not_full", 32'(full0), 32'd0);
        repeat (820) @(negedge clk);
        chk("sim_drained", 32'(exp_q0.size()), 32'd0);
        chk("sim_busy", 32'(busy0), 32'd0);
        chk("par_drained", 32'(exp_q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
